// File: rtl/hdmi_output_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// hdmi_output_sequencer_pkg
// Shared definitions for the HDMI output sequencer: FSM state encodings,
// pixel-source ids and a small state-classification helper.
// No ports (package).
// ---------------------------------------------------------------------------
package hdmi_output_sequencer_pkg;

    // FSM state encodings; these values are also what seq_state reports.
    localparam logic [2:0] ST_OFF         = 3'd0;
    localparam logic [2:0] ST_DEBOUNCE    = 3'd1;
    localparam logic [2:0] ST_SYNC        = 3'd2;
    localparam logic [2:0] ST_BLANK       = 3'd3;
    localparam logic [2:0] ST_ACTIVE      = 3'd4;
    localparam logic [2:0] ST_SWITCH_WAIT = 3'd5;
    localparam logic [2:0] ST_FAULT       = 3'd6;

    // Pixel source ids driven on src_active.
    localparam logic [1:0] SRC_TEST = 2'd0;
    localparam logic [1:0] SRC_CRT  = 2'd1;

    // Width of the blanked-frame counter (C_BLANK_FRAMES is 1..255).
    localparam int FCNT_W = 8;

    // States in which frame_start pulses are expected to keep arriving.
    function automatic logic is_running(input logic [2:0] st);
        return (st == ST_SYNC) || (st == ST_BLANK) ||
               (st == ST_ACTIVE) || (st == ST_SWITCH_WAIT);
    endfunction

endpackage

// File: rtl/hdmi_output_sequencer_if.sv
// ---------------------------------------------------------------------------
// hdmi_output_sequencer_if
// Source-change request channel into the HDMI output sequencer.
//   sel_req_valid  requester -> sequencer  request present
//   sel_req_src    requester -> sequencer  requested source id (2 bits)
//   sel_req_ready  sequencer -> requester  sequencer can take a request
// Handshake: a request transfers on every rising clock edge where
// sel_req_valid && sel_req_ready are both 1. While valid is high and ready is
// low the requester holds valid and src stable. Ready does not depend on valid.
// ---------------------------------------------------------------------------
interface hdmi_output_sequencer_if;
    logic       sel_req_valid;
    logic [1:0] sel_req_src;
    logic       sel_req_ready;

    modport master (
        output sel_req_valid,
        output sel_req_src,
        input  sel_req_ready
    );

    modport slave (
        input  sel_req_valid,
        input  sel_req_src,
        output sel_req_ready
    );
endinterface

// File: rtl/hdmi_output_sequencer_hpd_debounce.sv
// ---------------------------------------------------------------------------
// hdmi_output_sequencer_hpd_debounce
// Two-flop synchroniser for the raw monitor HPD pin followed by a saturating
// debounce counter that runs while the synchronised HPD is high.
//   clk            in   pixel clock
//   rst_n          in   asynchronous active-low reset
//   hpd_in         in   raw HPD, asynchronous
//   hpd_sync       out  HPD after the 2-flop synchroniser
//   hpd_debounced  out  1 on the edge the counter reaches C_HPD_DEBOUNCE and after
// ---------------------------------------------------------------------------
module hdmi_output_sequencer_hpd_debounce #(
    parameter int unsigned C_HPD_DEBOUNCE = 1020000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hpd_in,
    output logic hpd_sync,
    output logic hpd_debounced
);

    localparam int CW = $clog2(C_HPD_DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(C_HPD_DEBOUNCE);
    localparam logic [CW-1:0] CNT_LAST = CW'(C_HPD_DEBOUNCE - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = hpd_in;
        sync2_d = sync1_q;
        // Any low sample restarts the count from zero; saturate at the target.
        if (!sync2_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hpd_sync = sync2_q;
    // Asserted one count early so the FSM leaves DEBOUNCE on the same edge
    // that the counter reaches the target.
    assign hpd_debounced = sync2_q && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/hdmi_output_sequencer.sv
// ---------------------------------------------------------------------------
// hdmi_output_sequencer
// Sequences HDMI output bring-up and pixel-source switching in the pixel clock
// domain: debounces monitor HPD, waits for a frame boundary, blanks a set number
// of frames, then runs; source changes are applied only on frame boundaries.
//   clk_pixel     in   pixel clock (only clock)
//   rst_pixel_n   in   asynchronous active-low reset
//   frame_start   in   1-cycle pulse at h=0,v=0
//   hpd_in        in   raw HPD (asynchronous)
//   sel_req       if   source-change request channel (slave modport)
//   src_active    out  source select for the pixel mux
//   force_blank   out  1 = output must be blanked (state != ACTIVE)
//   hpd_stable    out  debounced HPD (state >= SYNC)
//   seq_state     out  current FSM state
//   wdog_fault    out  frame watchdog tripped
// Build option: define HDMI_SEQ_WDOG_EN to include the frame watchdog and the
// FAULT state; without it wdog_fault is tied 0 and FAULT is unreachable.
// ---------------------------------------------------------------------------
module hdmi_output_sequencer
    import hdmi_output_sequencer_pkg::*;
#(
    parameter int unsigned C_HPD_DEBOUNCE = 1020000,
    parameter int unsigned C_BLANK_FRAMES = 2,
    parameter logic [1:0]  C_DEFAULT_SRC  = SRC_TEST,
    parameter int unsigned C_WDOG_CYCLES  = 1100000
) (
    input  logic                     clk_pixel,
    input  logic                     rst_pixel_n,
    input  logic                     frame_start,
    input  logic                     hpd_in,
    hdmi_output_sequencer_if.slave   sel_req,
    output logic [1:0]               src_active,
    output logic                     force_blank,
    output logic                     hpd_stable,
    output logic [2:0]               seq_state,
    output logic                     wdog_fault
);

    localparam logic [FCNT_W-1:0] BLANK_LOAD = FCNT_W'(C_BLANK_FRAMES);

    logic              hpd_sync;
    logic              hpd_debounced;
    logic              accept;
    logic              wdog_trip;

    logic [2:0]        state_q, state_d;
    logic [1:0]        src_q, src_d;
    logic [1:0]        pend_q, pend_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;

    hdmi_output_sequencer_hpd_debounce #(
        .C_HPD_DEBOUNCE (C_HPD_DEBOUNCE)
    ) u_hpd_debounce (
        .clk           (clk_pixel),
        .rst_n         (rst_pixel_n),
        .hpd_in        (hpd_in),
        .hpd_sync      (hpd_sync),
        .hpd_debounced (hpd_debounced)
    );

    assign sel_req.sel_req_ready = (state_q == ST_OFF) || (state_q == ST_ACTIVE);
    assign accept = sel_req.sel_req_valid && sel_req.sel_req_ready;

`ifdef HDMI_SEQ_WDOG_EN
    localparam int WW = $clog2(C_WDOG_CYCLES + 1);
    localparam logic [WW-1:0] WDOG_MAX  = WW'(C_WDOG_CYCLES);
    localparam logic [WW-1:0] WDOG_LAST = WW'(C_WDOG_CYCLES - 1);

    logic [WW-1:0] wdog_cnt_q, wdog_cnt_d;

    // Counts cycles since the last frame_start while video should be flowing;
    // trips on the edge the count reaches the limit.
    always_comb begin
        wdog_cnt_d = '0;
        wdog_trip  = 1'b0;
        if (is_running(state_q) && !frame_start) begin
            wdog_cnt_d = (wdog_cnt_q == WDOG_MAX) ? wdog_cnt_q : wdog_cnt_q + WW'(1);
            wdog_trip  = (wdog_cnt_q >= WDOG_LAST);
        end
    end

    always_ff @(posedge clk_pixel or negedge rst_pixel_n) begin
        if (!rst_pixel_n) begin
            wdog_cnt_q <= '0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
        end
    end

    assign wdog_fault = (state_q == ST_FAULT);
`else
    // Timeout has no meaning without the watchdog built in.
    logic unused_wdog_cfg;
    assign unused_wdog_cfg = (C_WDOG_CYCLES != 0);
    assign wdog_trip  = 1'b0;
    assign wdog_fault = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        pend_d  = pend_q;
        fcnt_d  = fcnt_q;

        if ((state_q != ST_OFF) && !hpd_sync) begin
            // Monitor lost: drop straight to OFF. A request taken in ACTIVE
            // this cycle still lands, since nothing is being shown anyway.
            state_d = ST_OFF;
            if (accept) begin
                src_d = sel_req.sel_req_src;
            end
        end else if (wdog_trip) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_OFF: begin
                    // Output is blanked, so a source change can apply at once.
                    if (accept) begin
                        src_d = sel_req.sel_req_src;
                    end
                    if (hpd_sync) begin
                        state_d = ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (hpd_debounced) begin
                        state_d = ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (frame_start) begin
                        fcnt_d  = BLANK_LOAD;
                        state_d = ST_BLANK;
                    end
                end
                ST_BLANK: begin
                    if (frame_start) begin
                        if (fcnt_q <= FCNT_W'(1)) begin
                            state_d = ST_ACTIVE;
                        end else begin
                            fcnt_d = fcnt_q - FCNT_W'(1);
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (accept && (sel_req.sel_req_src != src_q)) begin
                        pend_d  = sel_req.sel_req_src;
                        state_d = ST_SWITCH_WAIT;
                    end
                end
                ST_SWITCH_WAIT: begin
                    if (frame_start) begin
                        src_d   = pend_q;
                        fcnt_d  = BLANK_LOAD;
                        state_d = ST_BLANK;
                    end
                end
                ST_FAULT: begin
                    if (frame_start) begin
                        state_d = ST_SYNC;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                end
            endcase
        end
    end

    always_ff @(posedge clk_pixel or negedge rst_pixel_n) begin
        if (!rst_pixel_n) begin
            state_q <= ST_OFF;
            src_q   <= C_DEFAULT_SRC;
            pend_q  <= C_DEFAULT_SRC;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            pend_q  <= pend_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign src_active  = src_q;
    assign force_blank = (state_q != ST_ACTIVE);
    assign hpd_stable  = (state_q >= ST_SYNC);
    assign seq_state   = state_q;

endmodule

// File: tb/tb_hdmi_output_sequencer.sv
// ---------------------------------------------------------------------------
// tb_hdmi_output_sequencer
// Self-checking bench for hdmi_output_sequencer with small parameters
// (debounce 16, 2 blank frames, watchdog 100, frame every 50 cycles).
// Inputs are driven 1 time unit after the rising edge; outputs are read there
// too. src_active changes are matched against an expected queue.
// ---------------------------------------------------------------------------
module tb_hdmi_output_sequencer;

    localparam int FRAME = 50;

    logic       clk_pixel = 1'b0;
    logic       rst_pixel_n;
    logic       frame_start = 1'b0;
    logic       hpd_in = 1'b0;
    logic [1:0] src_active;
    logic       force_blank;
    logic       hpd_stable;
    logic [2:0] seq_state;
    logic       wdog_fault;

    hdmi_output_sequencer_if sel_req();

    int errors = 0;
    int checks = 0;

    logic [1:0] exp_q[$];
    logic [1:0] prev_src  = 2'd0;
    logic [1:0] model_src = 2'd0;

    bit fs_en     = 1'b0;
    int phase     = 0;
    int fs_edges  = 0;

    hdmi_output_sequencer #(
        .C_HPD_DEBOUNCE (16),
        .C_BLANK_FRAMES (2),
        .C_DEFAULT_SRC  (2'd0),
        .C_WDOG_CYCLES  (100)
    ) dut (
        .clk_pixel   (clk_pixel),
        .rst_pixel_n (rst_pixel_n),
        .frame_start (frame_start),
        .hpd_in      (hpd_in),
        .sel_req     (sel_req.slave),
        .src_active  (src_active),
        .force_blank (force_blank),
        .hpd_stable  (hpd_stable),
        .seq_state   (seq_state),
        .wdog_fault  (wdog_fault)
    );

    // ---------------- clock / frame generator ----------------
    always #5 clk_pixel = ~clk_pixel;

    initial begin
        forever begin
            @(negedge clk_pixel);
            if (fs_en) begin
                if (phase == FRAME - 1) begin
                    phase = 0;
                    frame_start = 1'b1;
                end else begin
                    phase = phase + 1;
                    frame_start = 1'b0;
                end
            end else begin
                phase = 0;
                frame_start = 1'b0;
            end
        end
    end

    always @(posedge clk_pixel) begin
        if (frame_start) fs_edges <= fs_edges + 1;
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk_pixel) begin
        if (src_active !== prev_src) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL src_change_unexpected: got %0d, none expected", src_active);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                if (src_active !== e) begin
                    errors++;
                    $display("FAIL src_change: got %0d expected %0d", src_active, e);
                end
            end
            prev_src = src_active;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_pixel);
            #1;
        end
    endtask

    task automatic wait_frame();
        int e;
        e = fs_edges;
        for (int k = 0; k < 4 * FRAME && fs_edges == e; k++) tick();
        checks++;
        if (fs_edges == e) begin
            errors++;
            $display("FAIL frame_timeout: got no frame_start within %0d cycles", 4 * FRAME);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_pixel_n = 1'b0;
        sel_req.sel_req_valid = 1'b0;
        sel_req.sel_req_src   = 2'd0;
        tick(3);
        checks++; if (seq_state !== 3'd0)  begin errors++; $display("FAIL reset_state: got %0d expected 0", seq_state); end
        checks++; if (src_active !== 2'd0) begin errors++; $display("FAIL reset_src: got %0d expected 0", src_active); end
        checks++; if (force_blank !== 1'b1) begin errors++; $display("FAIL reset_blank: got %0b expected 1", force_blank); end
        checks++; if (hpd_stable !== 1'b0) begin errors++; $display("FAIL reset_hpd_stable: got %0b expected 0", hpd_stable); end
        checks++; if (wdog_fault !== 1'b0) begin errors++; $display("FAIL reset_wdog: got %0b expected 0", wdog_fault); end
        checks++; if (sel_req.sel_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", sel_req.sel_req_ready); end
        rst_pixel_n = 1'b1;
        tick(2);
        checks++; if (seq_state !== 3'd0) begin errors++; $display("FAIL idle_off: got %0d expected 0", seq_state); end
    endtask

    task automatic test_glitch();
        bit saw_sync;
        saw_sync = 1'b0;
        hpd_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (seq_state == 3'd2) saw_sync = 1'b1;
        end
        hpd_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (seq_state == 3'd2) saw_sync = 1'b1;
        end
        checks++; if (saw_sync !== 1'b0) begin errors++; $display("FAIL glitch_no_sync: got sync=%0b expected 0", saw_sync); end
        checks++; if (seq_state !== 3'd0) begin errors++; $display("FAIL glitch_off: got %0d expected 0", seq_state); end
    endtask

    // HPD rises; SYNC is reached on the 18th edge, then two blanked frames.
    task automatic test_bringup();
        fs_en = 1'b0;
        hpd_in = 1'b1;
        tick(17);
        checks++; if (seq_state !== 3'd1) begin errors++; $display("FAIL bringup_debounce: got %0d expected 1", seq_state); end
        tick();
        checks++; if (seq_state !== 3'd2) begin errors++; $display("FAIL bringup_sync: got %0d expected 2", seq_state); end
        checks++; if (hpd_stable !== 1'b1) begin errors++; $display("FAIL bringup_hpd_stable: got %0b expected 1", hpd_stable); end
        fs_en = 1'b1;
        wait_frame();
        checks++; if (seq_state !== 3'd3 || force_blank !== 1'b1) begin errors++; $display("FAIL bringup_blank1: got state=%0d blank=%0b expected 3/1", seq_state, force_blank); end
        wait_frame();
        checks++; if (seq_state !== 3'd3 || force_blank !== 1'b1) begin errors++; $display("FAIL bringup_blank2: got state=%0d blank=%0b expected 3/1", seq_state, force_blank); end
        wait_frame();
        checks++; if (seq_state !== 3'd4 || force_blank !== 1'b0) begin errors++; $display("FAIL bringup_active: got state=%0d blank=%0b expected 4/0", seq_state, force_blank); end
    endtask

    task automatic test_switch();
        sel_req.sel_req_valid = 1'b1;
        sel_req.sel_req_src   = 2'd1;
        checks++; if (sel_req.sel_req_ready !== 1'b1) begin errors++; $display("FAIL switch_ready: got %0b expected 1", sel_req.sel_req_ready); end
        exp_q.push_back(2'd1);
        model_src = 2'd1;
        tick();
        sel_req.sel_req_valid = 1'b0;
        checks++; if (seq_state !== 3'd5 || sel_req.sel_req_ready !== 1'b0) begin errors++; $display("FAIL switch_wait: got state=%0d ready=%0b expected 5/0", seq_state, sel_req.sel_req_ready); end
        checks++; if (src_active !== 2'd0 || force_blank !== 1'b1) begin errors++; $display("FAIL switch_hold: got src=%0d blank=%0b expected 0/1", src_active, force_blank); end
        wait_frame();
        checks++; if (src_active !== 2'd1 || seq_state !== 3'd3) begin errors++; $display("FAIL switch_apply: got src=%0d state=%0d expected 1/3", src_active, seq_state); end
        wait_frame();
        checks++; if (seq_state !== 3'd3) begin errors++; $display("FAIL switch_blank2: got %0d expected 3", seq_state); end
        wait_frame();
        checks++; if (seq_state !== 3'd4 || force_blank !== 1'b0) begin errors++; $display("FAIL switch_active: got state=%0d blank=%0b expected 4/0", seq_state, force_blank); end
    endtask

    task automatic test_same_src();
        sel_req.sel_req_valid = 1'b1;
        sel_req.sel_req_src   = model_src;
        tick();
        sel_req.sel_req_valid = 1'b0;
        tick(3);
        checks++; if (seq_state !== 3'd4 || force_blank !== 1'b0) begin errors++; $display("FAIL same_src: got state=%0d blank=%0b expected 4/0", seq_state, force_blank); end
        checks++; if (sel_req.sel_req_ready !== 1'b1) begin errors++; $display("FAIL same_src_ready: got %0b expected 1", sel_req.sel_req_ready); end
    endtask

    task automatic test_unplug();
        sel_req.sel_req_valid = 1'b1;
        sel_req.sel_req_src   = 2'd0;
        exp_q.push_back(2'd0);
        model_src = 2'd0;
        tick();
        sel_req.sel_req_valid = 1'b0;
        wait_frame();
        checks++; if (seq_state !== 3'd3 || hpd_stable !== 1'b1) begin errors++; $display("FAIL unplug_pre: got state=%0d hpd_stable=%0b expected 3/1", seq_state, hpd_stable); end
        hpd_in = 1'b0;
        tick(2);
        // Two synchroniser stages: the FSM has not seen the drop yet.
        checks++; if (seq_state !== 3'd3) begin errors++; $display("FAIL unplug_sync_lat: got %0d expected 3", seq_state); end
        tick();
        checks++; if (seq_state !== 3'd0 || force_blank !== 1'b1) begin errors++; $display("FAIL unplug_off: got state=%0d blank=%0b expected 0/1", seq_state, force_blank); end
        checks++; if (sel_req.sel_req_ready !== 1'b1 || hpd_stable !== 1'b0) begin errors++; $display("FAIL unplug_ready: got ready=%0b hpd_stable=%0b expected 1/0", sel_req.sel_req_ready, hpd_stable); end
    endtask

    task automatic test_off_request();
        logic [1:0] reqs[2];
        reqs[0] = 2'd1;
        reqs[1] = 2'(2 + $urandom_range(0, 1));
        for (int i = 0; i < 2; i++) begin
            sel_req.sel_req_valid = 1'b1;
            sel_req.sel_req_src   = reqs[i];
            if (reqs[i] != model_src) exp_q.push_back(reqs[i]);
            model_src = reqs[i];
            tick();
            sel_req.sel_req_valid = 1'b0;
            checks++; if (src_active !== reqs[i] || seq_state !== 3'd0) begin errors++; $display("FAIL off_request: got src=%0d state=%0d expected %0d/0", src_active, seq_state, reqs[i]); end
            tick(2);
        end
    endtask

    task automatic test_watchdog();
        test_bringup();
        fs_en = 1'b0;
        tick(99);
        checks++; if (seq_state !== 3'd4) begin errors++; $display("FAIL wdog_before: got %0d expected 4", seq_state); end
        tick();
`ifdef HDMI_SEQ_WDOG_EN
        checks++; if (seq_state !== 3'd6 || wdog_fault !== 1'b1) begin errors++; $display("FAIL wdog_fault: got state=%0d fault=%0b expected 6/1", seq_state, wdog_fault); end
        checks++; if (force_blank !== 1'b1 || sel_req.sel_req_ready !== 1'b0) begin errors++; $display("FAIL wdog_blank: got blank=%0b ready=%0b expected 1/0", force_blank, sel_req.sel_req_ready); end
        fs_en = 1'b1;
        wait_frame();
        checks++; if (seq_state !== 3'd2 || wdog_fault !== 1'b0) begin errors++; $display("FAIL wdog_resync: got state=%0d fault=%0b expected 2/0", seq_state, wdog_fault); end
        wait_frame();
        wait_frame();
        wait_frame();
        checks++; if (seq_state !== 3'd4) begin errors++; $display("FAIL wdog_recover: got %0d expected 4", seq_state); end
`else
        checks++; if (seq_state !== 3'd4 || wdog_fault !== 1'b0) begin errors++; $display("FAIL wdog_off: got state=%0d fault=%0b expected 4/0", seq_state, wdog_fault); end
        fs_en = 1'b1;
`endif
    endtask

    task automatic test_async_reset();
        if (model_src != 2'd0) exp_q.push_back(2'd0);
        model_src = 2'd0;
        tick();
        #2 rst_pixel_n = 1'b0;
        #1;
        checks++; if (seq_state !== 3'd0 || src_active !== 2'd0) begin errors++; $display("FAIL async_reset: got state=%0d src=%0d expected 0/0", seq_state, src_active); end
        checks++; if (force_blank !== 1'b1 || sel_req.sel_req_ready !== 1'b1 || hpd_stable !== 1'b0 || wdog_fault !== 1'b0) begin
            errors++; $display("FAIL async_reset_outs: got blank=%0b ready=%0b hs=%0b wf=%0b expected 1/1/0/0", force_blank, sel_req.sel_req_ready, hpd_stable, wdog_fault);
        end
        tick(2);
        rst_pixel_n = 1'b1;
        tick(2);
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_glitch();
        test_bringup();
        test_switch();
        test_same_src();
        test_unplug();
        test_off_request();
        test_watchdog();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
